imem_dmem: RTL and testbench

IMEM_DMEM -- requirements
Module: imem_dmem

---
 rtl/imem_dmem.sv | 85 ++++++++
 tb/tb_imem_dmem.sv | 115 +++++++++++
 2 files changed

// File: rtl/imem_dmem.sv
// imem_dmem: byte-addressed big-endian instruction ROM plus data RAM with byte/halfword/word writes
//   imem : addr[0:31] -> instr[0:31], combinational, contents loaded hierarchically via mem
//   dmem : addr/wData/rData[0:31], writeEnable, dsize (00 byte, 01 half, 1x word), clk, reset
//   imem_dmem : iaddr/instr, daddr/drdata/dwdata/dwrite/dsize, clk, reset (async, write inhibit only)

module imem #(
    parameter int SIZE = 1024
) (
    input  logic [0:31] addr,
    output logic [0:31] instr
);
    localparam int AW = SIZE > 1 ? $clog2(SIZE) : 1;
    localparam logic [31:0] SZ = 32'(SIZE);
    logic [7:0] mem [0:SIZE-1];
    // each byte of a word wraps independently around the end of memory
    function automatic logic [AW-1:0] idx(input logic [0:31] a, input logic [31:0] k);
        return AW'(((a % SZ) + k) % SZ);
    endfunction
    assign instr = {mem[idx(addr, 0)], mem[idx(addr, 1)], mem[idx(addr, 2)], mem[idx(addr, 3)]};
endmodule

module dmem #(
    parameter int SIZE = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] addr,
    output logic [0:31] rData,
    input  logic [0:31] wData,
    input  logic        writeEnable,
    input  logic [1:0]  dsize
);
    localparam int AW = SIZE > 1 ? $clog2(SIZE) : 1;
    localparam logic [31:0] SZ = 32'(SIZE);
    logic [7:0] mem [0:SIZE-1];
    function automatic logic [AW-1:0] idx(input logic [0:31] a, input logic [31:0] k);
        return AW'(((a % SZ) + k) % SZ);
    endfunction
    assign rData = {mem[idx(addr, 0)], mem[idx(addr, 1)], mem[idx(addr, 2)], mem[idx(addr, 3)]};
    // reset only blocks writes; contents survive it
    always_ff @(posedge clk or posedge reset) begin
        if (!reset && writeEnable) begin
            if (dsize == 2'b00) begin
                mem[idx(addr, 0)] <= wData[24:31];
            end else if (dsize == 2'b01) begin
                mem[idx(addr, 0)] <= wData[16:23];
                mem[idx(addr, 1)] <= wData[24:31];
            end else begin
                mem[idx(addr, 0)] <= wData[0:7];
                mem[idx(addr, 1)] <= wData[8:15];
                mem[idx(addr, 2)] <= wData[16:23];
                mem[idx(addr, 3)] <= wData[24:31];
            end
        end
    end
endmodule

module imem_dmem #(
    parameter int IMEM_SIZE = 1024,
    parameter int DMEM_SIZE = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] iaddr,
    output logic [0:31] instr,
    input  logic [0:31] daddr,
    output logic [0:31] drdata,
    input  logic [0:31] dwdata,
    input  logic        dwrite,
    input  logic [1:0]  dsize
);
    imem #(.SIZE(IMEM_SIZE)) IMEM (
        .addr (iaddr),
        .instr(instr)
    );
    dmem #(.SIZE(DMEM_SIZE)) DMEM (
        .clk        (clk),
        .reset      (reset),
        .addr       (daddr),
        .rData      (drdata),
        .wData      (dwdata),
        .writeEnable(dwrite),
        .dsize      (dsize)
    );
endmodule

// File: tb/tb_imem_dmem.sv
// tb_imem_dmem: directed checks of instruction reads, data reads, sized writes, wrap and reset inhibit
module tb_imem_dmem;
    logic        clk = 1'b0;
    logic        reset;
    logic [0:31] iaddr, instr, daddr, drdata, dwdata;
    logic        dwrite;
    logic [1:0]  dsize;
    int passed = 0;
    int total = 0;

    imem_dmem dut (
        .clk   (clk),
        .reset (reset),
        .iaddr (iaddr),
        .instr (instr),
        .daddr (daddr),
        .drdata(drdata),
        .dwdata(dwdata),
        .dwrite(dwrite),
        .dsize (dsize)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        daddr = a;
        dwdata = d;
        dsize = s;
        dwrite = 1'b1;
        @(posedge clk);
        #1;
        dwrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        daddr = a;
        #1;
        chk(tag, drdata, exp);
    endtask

    initial begin
        logic [7:0] ib [0:7];
        ib = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h10};
        reset = 1'b1;
        dwrite = 1'b0;
        dsize = 2'b00;
        dwdata = '0;
        daddr = '0;
        iaddr = '0;
        for (int i = 0; i < 1024; i++) dut.IMEM.mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) dut.IMEM.mem[i] = ib[i];
        dut.IMEM.mem[1022] = 8'hAA;
        dut.IMEM.mem[1023] = 8'hBB;
        for (int i = 0; i < 16384; i++) dut.DMEM.mem[i] = 8'h00;
        dut.DMEM.mem[16'h2000] = 8'h11;
        dut.DMEM.mem[16'h2001] = 8'h22;
        dut.DMEM.mem[16'h2002] = 8'h33;
        dut.DMEM.mem[16'h2003] = 8'h44;
        dut.DMEM.mem[16'h2004] = 8'h55;
        #1;
        chk("instr_0", instr, 32'h20010005);
        iaddr = 32'd4; #1;
        chk("instr_4", instr, 32'h8C220010);
        iaddr = 32'd1; #1;
        chk("instr_unaligned", instr, 32'h0100058C);
        iaddr = 32'h400; #1;
        chk("instr_alias", instr, 32'h20010005);
        iaddr = 32'h3FE; #1;
        chk("instr_wrap", instr, 32'hAABB2001);
        rd("rd_in_reset", 32'h2000, 32'h11223344);
        daddr = 32'h2001; #0;
        chk("rd_unaligned_same_step", drdata, 32'h22334455);
        @(posedge clk); #1;
        reset = 1'b0;
        wr(32'h100, 32'hAABBCCDD, 2'b10);
        rd("word_wr", 32'h100, 32'hAABBCCDD);
        wr(32'h101, 32'h000000EE, 2'b00);
        rd("byte_wr", 32'h100, 32'hAAEECCDD);
        wr(32'h200, 32'hFFFFFFFF, 2'b11);
        rd("word_wr_sz11", 32'h200, 32'hFFFFFFFF);
        wr(32'h200, 32'h00001234, 2'b01);
        rd("half_wr", 32'h200, 32'h1234FFFF);
        daddr = 32'h200; dwdata = 32'h99999999; dsize = 2'b10; dwrite = 1'b0;
        @(posedge clk); #1;
        chk("no_write_en", drdata, 32'h1234FFFF);
        wr(32'h3FFE, 32'h01020304, 2'b10);
        chk("wrap_m3ffe", {24'h0, dut.DMEM.mem[16'h3FFE]}, 32'h01);
        chk("wrap_m3fff", {24'h0, dut.DMEM.mem[16'h3FFF]}, 32'h02);
        chk("wrap_m0", {24'h0, dut.DMEM.mem[0]}, 32'h03);
        chk("wrap_m1", {24'h0, dut.DMEM.mem[1]}, 32'h04);
        rd("wrap_rd", 32'h3FFE, 32'h01020304);
        rd("wrap_rd0", 32'h0, 32'h03040000);
        rd("alias_7ffe", 32'h7FFE, 32'h01020304);
        daddr = 32'h300; dwdata = 32'h55667788; dsize = 2'b10; dwrite = 1'b1; #1;
        chk("rdw_before", drdata, 32'h00000000);
        @(posedge clk); #1;
        dwrite = 1'b0;
        chk("rdw_after", drdata, 32'h55667788);
        reset = 1'b1;
        wr(32'h40, 32'hDEADBEEF, 2'b10);
        rd("reset_inhibit", 32'h40, 32'h00000000);
        rd("reset_keeps", 32'h100, 32'hAAEECCDD);
        reset = 1'b0;
        wr(32'h40, 32'hDEADBEEF, 2'b10);
        rd("after_reset", 32'h40, 32'hDEADBEEF);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
